// File: rtl/if_id_stage_pkg.sv
// Shared definitions for the pipeline-register family: occupancy state
// encoding of the 2-entry elastic buffer and the default bubble instruction.
package if_id_stage_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } skid_state_e;

   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_id_stage_skid_buffer2.sv
// Generic 2-entry elastic buffer with flush; in_ready is registered so the
// upstream ready path is cut, the second entry absorbs the in-flight push.
module skid_buffer2
   import if_id_stage_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   skid_state_e      r_state;
   logic [WIDTH-1:0] r_main;
   logic [WIDTH-1:0] r_skid;
   logic             r_valid;
   logic             r_in_ready;
   logic             w_push;
   logic             w_pop;

   // Ready is held low for as long as reset is asserted, then reflects the
   // registered "next state is not TWO" value.
   assign in_ready  = r_in_ready & ~reset;
   assign out_valid = r_valid;
   assign out_data  = r_main;
   assign w_push    = in_valid & in_ready;
   assign w_pop     = r_valid & out_ready;

   // Occupancy FSM with main/skid storage and registered ready.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= EMPTY;
         r_main     <= '0;
         r_skid     <= '0;
         r_valid    <= 1'b0;
         r_in_ready <= 1'b1;
      end else if (flush) begin
         r_state    <= EMPTY;
         r_main     <= '0;
         r_skid     <= '0;
         r_valid    <= 1'b0;
         r_in_ready <= 1'b1;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_push) begin
                  r_state <= ONE;
                  r_main  <= in_data;
                  r_valid <= 1'b1;
               end
            end
            ONE: begin
               if (w_push && w_pop) begin
                  r_main <= in_data;
               end else if (w_push) begin
                  r_state    <= TWO;
                  r_skid     <= in_data;
                  r_in_ready <= 1'b0;
               end else if (w_pop) begin
                  r_state <= EMPTY;
                  r_valid <= 1'b0;
               end
            end
            TWO: begin
               if (w_pop) begin
                  r_state    <= ONE;
                  r_main     <= r_skid;
                  r_in_ready <= 1'b1;
               end
            end
            default: begin
               r_state    <= EMPTY;
               r_main     <= '0;
               r_skid     <= '0;
               r_valid    <= 1'b0;
               r_in_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register: elastic 2-entry buffer between fetch and decode,
// with hazard stall gating, bubble substitution and a debug stall counter.
module if_id_stage
   import if_id_stage_pkg::*;
#(
   parameter int                 INSTR_W   = 32,
   parameter int                 PC_W      = 32,
   parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEFAULT),
   parameter int                 CNT_W     = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               stall,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] instruccion_in,
   input  logic [PC_W-1:0]    pc4_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] instruccion_out,
   output logic [PC_W-1:0]    pc4_out,
   output logic [CNT_W-1:0]   stall_cnt
);

   localparam int W = INSTR_W + PC_W;

   logic             w_valid;
   logic             w_take;
   logic [W-1:0]     w_head;
   logic [CNT_W-1:0] r_stall_cnt;

   // Decode only consumes when the hazard unit is not holding the stage.
   assign w_take = out_ready & ~stall;

   skid_buffer2 #(
      .WIDTH (W)
   ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   ({instruccion_in, pc4_in}),
      .out_valid (w_valid),
      .out_ready (w_take),
      .out_data  (w_head)
   );

   assign out_valid       = w_valid;
   assign instruccion_out = w_valid ? w_head[W-1:PC_W] : NOP_INSTR;
   assign pc4_out         = w_valid ? w_head[PC_W-1:0] : '0;
   assign stall_cnt       = r_stall_cnt;

   // Saturating count of cycles where a valid head was held back.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cnt <= '0;
      end else if (w_valid && (stall || !out_ready) && !(&r_stall_cnt)) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

endmodule
